// File: rtl/decode_ctrl_pkg.sv
// decode_ctrl_pkg
// Shared types and helpers for the decode-system control unit: the FSM state
// enum, the ENCODE/DECODE mode constants and the width helpers that size the
// output-buffer pointer and the cycle counters.
package decode_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOOKUP,
    EMIT,
    BRANCH
  } state_t;

  localparam logic ENCODE = 1'b1;
  localparam logic DECODE = 1'b0;

  // Pointer width for n output buffers; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  // Counter width able to hold the value n.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/decode_ctrl_counter.sv
// decode_ctrl_counter
// Loadable up-counter with synchronous clear and a terminal-count compare.
// Ports:
//   clk_i       rising-edge clock
//   rst_ni      asynchronous active-low reset
//   clr_i       synchronous clear (highest priority)
//   load_i      load load_val_i
//   load_val_i  value to load
//   en_i        count up by one
//   cnt_o       current count
//   tc_o        high while cnt_o equals TC
module decode_ctrl_counter #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned TC    = 15
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] TC_V = WIDTH'(TC);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)       cnt_d = '0;
    else if (load_i) cnt_d = load_val_i;
    else if (en_i)   cnt_d = cnt_q + WIDTH'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == TC_V);

endmodule

// File: rtl/decode_control_unit.sv
// decode_control_unit
// Control FSM for the compress/decompress datapath: sequences fetch, table
// lookup, output emission and branch redirection, and drives the datapath
// load/select strobes.
// Ports:
//   clk, reset (async, active low)
//   PCcpu, branch, encode      CPU request strobe, redirect flag, mode
//   tableReady, outReady       lookup-result valid, downstream accept
//   branchMux, PCcompress, inputBuff, tableMux, outMux, PCintern
//                              datapath select/load strobes
//   outBuff[N_OUT_BUFF]        one-hot load of the active output buffer
//   busy                       high outside IDLE
//   error                      one-cycle pulse on table timeout
module decode_control_unit
  import decode_ctrl_pkg::*;
#(
  parameter int unsigned N_OUT_BUFF     = 2,
  parameter int unsigned BRANCH_PENALTY = 2,
  parameter int unsigned TABLE_TIMEOUT  = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  PCcpu,
  input  logic                  branch,
  input  logic                  encode,
  input  logic                  tableReady,
  input  logic                  outReady,
  output logic                  branchMux,
  output logic                  PCcompress,
  output logic                  inputBuff,
  output logic                  tableMux,
  output logic                  outMux,
  output logic                  PCintern,
  output logic [N_OUT_BUFF-1:0] outBuff,
  output logic                  busy,
  output logic                  error
);

  localparam int unsigned            PTR_W    = ptr_w(N_OUT_BUFF);
  localparam int unsigned            BCNT_W   = cnt_w(BRANCH_PENALTY);
  localparam int unsigned            TCNT_W   = cnt_w(TABLE_TIMEOUT);
  localparam logic [PTR_W-1:0]       PTR_LAST = PTR_W'(N_OUT_BUFF - 1);
  localparam logic [N_OUT_BUFF-1:0]  BUF_ONE  = N_OUT_BUFF'(1);

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              mode_q, mode_d;
  logic              error_q, error_d;

  logic              preempt, final_beat;
  logic              bcnt_clr, bcnt_en, bcnt_tc;
  logic [BCNT_W-1:0] bcnt;
  logic              tcnt_clr, tcnt_en, tcnt_tc;
  logic [TCNT_W-1:0] tcnt_unused;

  // A redirect arriving during LOOKUP or EMIT aborts the in-flight request.
  assign preempt    = PCcpu && branch && (state_q == LOOKUP || state_q == EMIT);
  assign final_beat = (mode_q == ENCODE) ? (ptr_q == '0) : (ptr_q == PTR_LAST);

  // Branch penalty: counts BRANCH cycles, held at zero elsewhere.
  assign bcnt_clr = (state_q != BRANCH);
  assign bcnt_en  = (state_q == BRANCH);

  decode_ctrl_counter #(
    .WIDTH (BCNT_W),
    .TC    (BRANCH_PENALTY - 1)
  ) u_branch_cnt (
    .clk_i      (clk),
    .rst_ni     (reset),
    .clr_i      (bcnt_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (bcnt_en),
    .cnt_o      (bcnt),
    .tc_o       (bcnt_tc)
  );

  // Table timeout: counts LOOKUP wait cycles; tc marks the last allowed one.
  assign tcnt_clr = (state_q != LOOKUP) || preempt;
  assign tcnt_en  = (state_q == LOOKUP) && !tableReady;

  decode_ctrl_counter #(
    .WIDTH (TCNT_W),
    .TC    (TABLE_TIMEOUT - 1)
  ) u_timeout_cnt (
    .clk_i      (clk),
    .rst_ni     (reset),
    .clr_i      (tcnt_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (tcnt_en),
    .cnt_o      (tcnt_unused),
    .tc_o       (tcnt_tc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      mode_q  <= DECODE;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      mode_q  <= mode_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mode_d  = mode_q;
    error_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (PCcpu) begin
          mode_d  = encode;
          state_d = branch ? BRANCH : FETCH;
        end
      end
      FETCH: state_d = LOOKUP;
      LOOKUP: begin
        // Priority: preemption, then tableReady, then timeout.
        if (preempt) begin
          mode_d  = encode;
          ptr_d   = '0;
          state_d = BRANCH;
        end else if (tableReady) begin
          ptr_d   = '0;
          state_d = EMIT;
        end else if (tcnt_tc) begin
          error_d = 1'b1;
          state_d = IDLE;
        end
      end
      EMIT: begin
        if (preempt) begin
          mode_d  = encode;
          ptr_d   = '0;
          state_d = BRANCH;
        end else if (outReady) begin
          if (final_beat) begin
            ptr_d   = '0;
            state_d = IDLE;
          end else begin
            ptr_d = ptr_q + PTR_W'(1);
          end
        end
      end
      BRANCH: if (bcnt_tc) state_d = FETCH;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    branchMux  = 1'b0;
    PCcompress = 1'b0;
    inputBuff  = 1'b0;
    tableMux   = 1'b0;
    outMux     = 1'b0;
    PCintern   = 1'b0;
    outBuff    = '0;
    busy       = (state_q != IDLE);
    error      = error_q;
    unique case (state_q)
      FETCH: begin
        inputBuff  = 1'b1;
        PCcompress = mode_q;
      end
      LOOKUP: tableMux = mode_q;
      EMIT: begin
        outMux  = 1'b1;
        outBuff = BUF_ONE << ptr_q;
        // Completion strobe only on an accepted final beat that is not being
        // preempted in the same cycle.
        PCintern = final_beat && outReady && !preempt;
      end
      BRANCH: begin
        branchMux = 1'b1;
        PCintern  = (bcnt == '0);
      end
      default: ;
    endcase
  end

endmodule
